// File: rtl/instruction_sequencer.sv
// Program-store sequencer: issues stored 16-bit instructions one at a time to the
// processor, waiting for each completion, with a watchdog that aborts a stalled sequence.
module instruction_sequencer #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 63
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              done,
    output logic              run,
    output logic [15:0]       DIN,
    output logic              busy,
    output logic              finished,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_LEN   = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      TIMEOUT_CNT = 8'(TIMEOUT);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic [15:0]         din_reg, din_next;
    logic [ADDR_W:0]     len_reg, len_next;
    logic [7:0]          cnt_reg, cnt_next;
    logic                terr_reg, terr_next;
    logic [ADDR_W-1:0]   pc_inc;
    logic [DEPTH-1:0]    word_we;

    logic [15:0] mem [DEPTH];

    // Per-word write enables; writes are locked out for the whole active sequence.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign word_we[gi] = wr_en && !busy && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_50MHz) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (word_we[i]) begin
                mem[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            din_reg   <= '0;
            len_reg   <= '0;
            cnt_reg   <= '0;
            terr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            din_reg   <= din_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            terr_reg  <= terr_next;
        end
    end

    assign pc_inc = pc_reg + ADDR_W'(1);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        din_next   = din_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        terr_next  = terr_reg;
        run        = 1'b0;
        finished   = 1'b0;
        busy       = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    terr_next = 1'b0;
                    if (prog_len != '0) begin
                        len_next   = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
                        pc_next    = '0;
                        din_next   = mem[0];
                        state_next = ISSUE;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            ISSUE: begin
                // A done arriving here predates this issue and is deliberately dropped.
                run        = 1'b1;
                cnt_next   = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (done) begin
                    if ({1'b0, pc_reg} == len_reg - (ADDR_W+1)'(1)) begin
                        state_next = FIN;
                    end else begin
                        pc_next    = pc_inc;
                        din_next   = mem[pc_inc];
                        state_next = ISSUE;
                    end
                end else if (cnt_reg == TIMEOUT_CNT) begin
                    terr_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            FIN: begin
                finished   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign DIN         = din_reg;
    assign pc          = pc_reg;
    assign timeout_err = terr_reg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: a protocol-level reference model checked every cycle,
// a reactive processor stub producing done, and directed scenarios with literal expectations.
module tb_instruction_sequencer;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 63;

    logic              clk_50MHz = 1'b0;
    logic              reset = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [15:0]       wr_data = '0;
    logic [ADDR_W:0]   prog_len = '0;
    logic              start = 1'b0;
    logic              done = 1'b0;
    logic              run;
    logic [15:0]       DIN;
    logic              busy;
    logic              finished;
    logic              timeout_err;
    logic [ADDR_W-1:0] pc;

    instruction_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_50MHz(clk_50MHz), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .prog_len(prog_len), .start(start), .done(done),
        .run(run), .DIN(DIN), .busy(busy), .finished(finished),
        .timeout_err(timeout_err), .pc(pc)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an in-flight program described by index, wait count and flags.
    logic [15:0] m_mem [DEPTH];
    bit          m_busy, m_issue, m_fin, m_terr, m_was_busy;
    int          m_idx, m_len, m_waited;
    logic [15:0] m_din;
    int          cyc = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end

    always @(posedge clk_50MHz) begin
        m_was_busy = m_busy;
        cyc++;
        if (reset) begin
            m_busy = 0; m_issue = 0; m_fin = 0; m_terr = 0;
            m_idx = 0; m_din = '0; m_waited = 0;
        end else if (m_fin) begin
            m_fin = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (start) begin
                m_terr = 0;
                m_busy = 1;
                if (prog_len == 0) begin
                    m_fin = 1;
                end else begin
                    m_len = (int'(prog_len) > DEPTH) ? DEPTH : int'(prog_len);
                    m_idx = 0;
                    m_din = m_mem[0];
                    m_issue = 1;
                end
            end
        end else if (m_issue) begin
            m_issue = 0;
            m_waited = 0;
        end else begin
            m_waited++;
            if (done) begin
                if (m_idx == m_len - 1) begin
                    m_fin = 1;
                end else begin
                    m_idx++;
                    m_din = m_mem[m_idx];
                    m_issue = 1;
                end
            end else if (m_waited == TIMEOUT + 1) begin
                m_terr = 1;
                m_busy = 0;
            end
        end
        if (wr_en && !m_was_busy) m_mem[wr_addr] = wr_data;
    end

    // Processor stub: answers done p_delay cycles after run, or same-cycle plus 2 later.
    int          p_delay = 3;
    bit          p_same = 0;
    bit          p_skip_en = 0;
    logic [15:0] p_skip = '0;
    int          p_cnt = 0;

    always @(posedge clk_50MHz) begin
        #1;
        done = 1'b0;
        if (reset) begin
            p_cnt = 0;
        end else begin
            if (p_cnt > 0) begin
                p_cnt--;
                if (p_cnt == 0) done = 1'b1;
            end
            if (run) begin
                if (p_same) begin
                    done = 1'b1;
                    p_cnt = 2;
                end else if (!(p_skip_en && DIN == p_skip)) begin
                    p_cnt = p_delay;
                end
            end
        end
    end

    // Compare process and transaction log.
    bit          cmp_en = 0;
    logic [15:0] din_log[$];
    int          pc_log[$];
    int          run_cyc[$];
    int          fin_cnt = 0;
    int          terr_cyc = 0;
    bit          prev_terr = 0;

    always @(negedge clk_50MHz) begin
        if (cmp_en) begin
            check("run",         32'(run),         32'(m_issue));
            check("DIN",         32'(DIN),         32'(m_din));
            check("pc",          32'(pc),          32'(m_idx));
            check("busy",        32'(busy),        32'(m_busy));
            check("finished",    32'(finished),    32'(m_fin));
            check("timeout_err", 32'(timeout_err), 32'(m_terr));
            if (run) begin
                din_log.push_back(DIN);
                pc_log.push_back(int'(pc));
                run_cyc.push_back(cyc);
                $display("cycle %0d: issue pc=%0d DIN=%h", cyc, pc, DIN);
            end
            if (finished) begin
                fin_cnt++;
                $display("cycle %0d: finished", cyc);
            end
            if (timeout_err && !prev_terr) begin
                terr_cyc = cyc;
                $display("cycle %0d: timeout abort", cyc);
            end
            prev_terr = timeout_err;
        end
    end

    task automatic tick();
        @(posedge clk_50MHz);
        #2;
    endtask

    task automatic load(input int addr, input logic [15:0] data);
        wr_en = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic clear_logs();
        din_log.delete();
        pc_log.delete();
        run_cyc.delete();
        fin_cnt = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check({name, "_idle_bound"}, 32'(busy), 32'd0);
    endtask

    task automatic run_prog(input int len, input string name, input int budget);
        prog_len = (ADDR_W+1)'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(name, budget);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        tick();
        cmp_en = 1;
        tick();
        reset = 1'b0;
        check("reset_run",  32'(run),  32'd0);
        check("reset_DIN",  32'(DIN),  32'd0);
        check("reset_pc",   32'(pc),   32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Basic program, done three cycles after each run.
        load(0, 16'h1001); load(1, 16'h1202); load(2, 16'h4001);
        clear_logs();
        run_prog(3, "t1", 100);
        check("t1_runs", 32'(din_log.size()), 32'd3);
        if (din_log.size() == 3) begin
            check("t1_din0", 32'(din_log[0]), 32'h1001);
            check("t1_din1", 32'(din_log[1]), 32'h1202);
            check("t1_din2", 32'(din_log[2]), 32'h4001);
            check("t1_pc2",  32'(pc_log[2]),  32'd2);
            check("t1_gap",  32'(run_cyc[1] - run_cyc[0]), 32'd4);
        end
        check("t1_fin", 32'(fin_cnt), 32'd1);
        check("t1_terr", 32'(timeout_err), 32'd0);

        // Same-cycle done must be ignored.
        p_same = 1;
        clear_logs();
        run_prog(3, "t2", 100);
        check("t2_runs", 32'(din_log.size()), 32'd3);
        check("t2_fin", 32'(fin_cnt), 32'd1);
        p_same = 0;

        // Stalled second instruction triggers watchdog.
        load(1, 16'h6001);
        p_skip_en = 1; p_skip = 16'h6001;
        clear_logs();
        run_prog(3, "t3", 200);
        check("t3_runs", 32'(din_log.size()), 32'd2);
        check("t3_terr", 32'(timeout_err), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        if (run_cyc.size() >= 2) check("t3_wait_cycles", 32'(terr_cyc - run_cyc[1] - 1), 32'd64);
        p_skip_en = 0;

        // Zero-length start: finished next cycle, no run, clears the error.
        clear_logs();
        prog_len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_fin_pulse", 32'(finished), 32'd1);
        check("t4_no_run", 32'(run), 32'd0);
        check("t4_terr_clr", 32'(timeout_err), 32'd0);
        tick();
        check("t4_busy_low", 32'(busy), 32'd0);
        check("t4_runs", 32'(din_log.size()), 32'd0);

        // Oversized length is clamped to the store depth.
        for (int i = 0; i < DEPTH; i++) load(i, 16'hA000 + 16'(i));
        p_delay = 1;
        clear_logs();
        run_prog(20, "t5", 400);
        check("t5_runs", 32'(din_log.size()), 32'd16);
        if (din_log.size() == 16) begin
            check("t5_last_pc",  32'(pc_log[15]),  32'd15);
            check("t5_last_din", 32'(din_log[15]), 32'hA00F);
        end
        check("t5_fin", 32'(fin_cnt), 32'd1);

        // Write while busy is dropped.
        load(0, 16'h1001); load(1, 16'h1202); load(2, 16'h4001);
        p_delay = 3;
        prog_len = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'hFFFF;
        tick();
        wr_en = 1'b0;
        wait_idle("t6a", 100);
        tick();
        clear_logs();
        run_prog(3, "t6", 100);
        check("t6_runs", 32'(din_log.size()), 32'd3);
        if (din_log.size() == 3) check("t6_din1", 32'(din_log[1]), 32'h1202);

        // Reset while waiting mid-program.
        prog_len = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_run",      32'(run),         32'd0);
        check("t7_DIN",      32'(DIN),         32'd0);
        check("t7_pc",       32'(pc),          32'd0);
        check("t7_busy",     32'(busy),        32'd0);
        check("t7_finished", 32'(finished),    32'd0);
        check("t7_terr",     32'(timeout_err), 32'd0);
        clear_logs();
        repeat (5) tick();
        check("t7_no_run", 32'(din_log.size()), 32'd0);
        run_prog(3, "t7", 100);
        check("t7_runs", 32'(din_log.size()), 32'd3);
        if (din_log.size() == 3) begin
            check("t7_pc0",  32'(pc_log[0]),  32'd0);
            check("t7_din0", 32'(din_log[0]), 32'h1001);
            check("t7_din2", 32'(din_log[2]), 32'h4001);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Drives the `simple_processor` instruction port from a small on-chip program store, replacing the bench-driven `DIN`/`run` stimulus. It loads a program through a write port. On `start`, it issues each 16-bit instruction with a one-cycle `run` pulse, then waits for the processor's `done` before issuing the next. A watchdog aborts the sequence if `done` never arrives.

## Interface
- `DEPTH`, 16, number of program words (power of two).
- `ADDR_W`, 4, log2(`DEPTH`).
- `TIMEOUT`, 63, maximum cycles spent in WAIT before abort (1..255).
- `clk_50MHz`  input  1  single clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `wr_en`  input  1  program-store write strobe.
- `wr_addr`  input  ADDR_W  program-store write address.
- `wr_data`  input  16  instruction word to store.
- `prog_len`  input  ADDR_W+1  number of instructions to run; sampled on accepted `start`.
- `start`  input  1  begin execution at address 0.
- `done`  input  1  processor completion pulse.
- `run`  output  1  one-cycle issue strobe to the processor.
- `DIN`  output  16  instruction to the processor; registered.
- `busy`  output  1  high from accepted `start` until return to IDLE.
- `finished`  output  1  one-cycle pulse after the last instruction's `done`.
- `timeout_err`  output  1  sticky abort flag.
- `pc`  output  ADDR_W  address of the instruction currently issued or awaited.

## Operation
- Program store: `DEPTH`×16 register array.
  - Write is `mem[wr_addr] <= wr_data` when `wr_en` is high and `busy` is low.
  - Writes while `busy` is high are dropped.
  - The store is not cleared by `reset`.
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE:
  - `start` with `prog_len` ≠ 0 is accepted. The block latches `len = min(prog_len, DEPTH)`, sets `pc <= 0` and `DIN <= mem[0]`, clears `timeout_err`, and moves to ISSUE.
  - `start` with `prog_len` = 0 moves to FIN without issuing; `timeout_err` is cleared.
- ISSUE:
  - `run` = 1 for exactly this one cycle; `busy` = 1.
  - Clears the watchdog counter.
  - Moves to WAIT unconditionally.
  - `done` seen in this cycle is ignored, since it belongs to no issued instruction.
- WAIT:
  - `DIN` and `pc` are held stable.
  - On `done`, if `pc` = `len`−1, move to FIN.
  - On `done` otherwise, set `pc <= pc+1` and `DIN <= mem[pc+1]`, then move to ISSUE.
  - With no `done`, the counter increments. When it reaches `TIMEOUT`, set `timeout_err <= 1` and move to IDLE.
  - `done` in the same cycle the counter reaches `TIMEOUT` wins: it is treated as completion.
- FIN: `finished` = 1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- `done` in IDLE or FIN is ignored.
- Reset values: state IDLE, `run` 0, `DIN` 0, `busy` 0, `finished` 0, `timeout_err` 0, `pc` 0, watchdog counter 0.
- Reset mid-sequence: the next cycle is IDLE with all outputs at their reset values. No further `run` is issued.

## Timing
- Accepted `start` at edge T: `run` high in cycle T+1, with `DIN` valid from T+1.
- `busy` rises at T+1 and stays high through the FIN cycle.
- Instruction issue: `DIN` is stable from its `run` cycle until the next ISSUE, covering multi-cycle processor instructions.
- `done` sampled at edge W with more instructions pending: next `run` in cycle W+1, so there is one dead cycle minimum between `run` pulses.
- Last `done` at edge W: `finished` high in cycle W+1, IDLE at W+2. A new `start` is accepted at W+2.
- Timeout: abort at the edge ending the WAIT cycle in which the counter equals `TIMEOUT`, which is `TIMEOUT`+1 WAIT cycles after `run`. `timeout_err` rises and `busy` falls at the same edge.
- `prog_len` = 0: `finished` in cycle T+1, `busy` high only in T+1.

## Test plan
- Load 0x1001, 0x1202, 0x4001 (mv r0,#1; mv r1,#2; add r0,r1), `prog_len`=3, `start`, with the processor model answering `done` 3 cycles after `run`.
  - Required: three `run` pulses carrying `DIN` 0x1001, 0x1202, 0x4001 in order, and `pc` stepping 0, 1, 2.
  - Required: exactly one `finished`, and `timeout_err`=0.
- Same program, model asserts `done` in the same cycle as `run`, then again 2 cycles later.
  - Required: the same-cycle `done` is ignored and the sequence completes normally, 3 issues total.
- Model never asserts `done` for the second instruction (0x6001), with `TIMEOUT`=63.
  - Required: `timeout_err`=1 exactly 64 WAIT cycles after the second `run`, `busy`=0, and no third `run`.
  - Required: a subsequent `start` clears `timeout_err`.
- `prog_len`=0 `start` gives a `finished` pulse in cycle T+1 and no `run`. `prog_len`=20 with `DEPTH`=16 gives exactly 16 issues.
- Assert `wr_en` to address 1 with data 0xFFFF while `busy`; re-run the program.
  - Required: `DIN` for `pc`=1 is still the original word.
- Assert `reset` while in WAIT mid-program.
  - Required: the next cycle has all outputs at reset values and no `run`; the program store still holds its contents.
  - Required: the next `start` reissues from `pc`=0.
